// File: rtl/shmemif_dma.sv
// shmemif_dma: block DMA initiator driving one shmemif arbiter port.
// Writes consume a valid/ready stream; reads fill a 2-entry FWFT FIFO.
module shmemif_dma #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wren,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  cmd_done,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  shmem_request,
   output logic                  shmem_wren,
   output logic [ADDR_WIDTH-1:0] shmem_addr,
   output logic [DATA_WIDTH-1:0] shmem_datain,
   input  logic [DATA_WIDTH-1:0] shmem_dataout,
   input  logic                  shmem_done
);
   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic [DATA_WIDTH-1:0] fifo_d [2];
   logic                  req_q, req_d, wren_q, wren_d, done_q, done_d;
   logic                  wp_q, wp_d, rp_q, rp_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  acc_done, last_ret, push, pop, wr_acc;
   assign acc_done      = req_q & shmem_done;
   assign last_ret      = acc_done & (rem_q == LEN_WIDTH'(1));
   assign cmd_ready     = state_q == IDLE;
   assign wr_ready      = (state_q == WRITE) & (rem_q != '0) & (!req_q | shmem_done) & !last_ret;
   assign wr_acc        = wr_valid & wr_ready;
   assign push          = acc_done & (state_q == READ);
   assign rd_valid      = cnt_q != 2'd0;
   assign pop           = rd_valid & rd_ready;
   assign rd_data       = fifo_q[rp_q];
   assign cmd_done      = done_q;
   assign shmem_request = req_q;
   assign shmem_wren    = wren_q;
   assign shmem_addr    = addr_q;
   assign shmem_datain  = wdat_q;
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q - LEN_WIDTH'(acc_done);
      addr_d  = addr_q + ADDR_WIDTH'(acc_done);
      req_d   = req_q;
      wren_d  = wren_q;
      wdat_d  = wdat_q;
      done_d  = last_ret;
      fifo_d  = fifo_q;
      wp_d    = wp_q ^ push;
      rp_d    = rp_q ^ pop;
      cnt_d   = cnt_q + 2'(push) - 2'(pop);
      if (push) fifo_d[wp_q] = shmem_dataout;
      if (state_q == IDLE) begin
         if (cmd_valid && cmd_len == '0) done_d = 1'b1;
         if (cmd_valid && cmd_len != '0) begin
            state_d = cmd_wren ? WRITE : READ;
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            wren_d  = cmd_wren;
            req_d   = !cmd_wren & (cnt_d < 2'd2);
         end
      end else if (last_ret) begin
         state_d = IDLE;
         req_d   = 1'b0;
      end else if (state_q == WRITE) begin
         req_d = wr_acc | (req_q & !shmem_done);
         if (wr_acc) wdat_d = wr_data;
      end else begin
         // an outstanding read is always counted into FIFO space when issued
         req_d = cnt_d < 2'd2;
      end
   end
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         addr_q  <= '0;
         wdat_q  <= '0;
         req_q   <= 1'b0;
         wren_q  <= 1'b0;
         done_q  <= 1'b0;
         fifo_q  <= '{default: '0};
         wp_q    <= 1'b0;
         rp_q    <= 1'b0;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         req_q   <= req_d;
         wren_q  <= wren_d;
         done_q  <= done_d;
         fifo_q  <= fifo_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_shmemif_dma.sv
// tb_shmemif_dma: directed checks of shmemif_dma against a one-cycle arbiter/memory model.
module tb_shmemif_dma;
   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_wren = 1'b0;
   logic [11:0] cmd_addr = '0;
   logic [12:0] cmd_len = '0;
   logic        cmd_ready, cmd_done, wr_ready, rd_valid;
   logic        wr_valid, rd_ready = 1'b0;
   logic [31:0] wr_data, rd_data, shmem_datain, shmem_dataout;
   logic        shmem_request, shmem_wren, shmem_done;
   logic [11:0] shmem_addr;
   logic [31:0] mem [4096];
   logic [31:0] alog [64];
   logic [31:0] rlog [64];
   int          nacc = 0, nrd = 0, ndone = 0, nfall = 0, wbeats = 0;
   int          checks = 0, errors = 0;
   int          abase, rbase, dbase, fbase, wbase = 0, cyc;
   logic [31:0] data_base = '0;
   logic        wv_en = 1'b0, gap = 1'b0, phase = 1'b0, req_prev = 1'b0;

   shmemif_dma dut (
      .clk(clk), .arst(arst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wren(cmd_wren),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .shmem_request(shmem_request), .shmem_wren(shmem_wren), .shmem_addr(shmem_addr),
      .shmem_datain(shmem_datain), .shmem_dataout(shmem_dataout), .shmem_done(shmem_done)
   );

   always #5 clk = ~clk;

   assign shmem_done    = shmem_request;
   assign shmem_dataout = mem[shmem_addr];
   assign wr_valid      = wv_en & (!gap | phase);
   assign wr_data       = data_base + 32'(wbeats - wbase);

   always @(posedge clk) begin
      if (shmem_request && shmem_done) begin
         alog[nacc] <= {20'd0, shmem_addr};
         nacc <= nacc + 1;
         if (shmem_wren) mem[shmem_addr] <= shmem_datain;
      end
      if (rd_valid && rd_ready) begin
         rlog[nrd] <= rd_data;
         nrd <= nrd + 1;
      end
      if (wr_valid && wr_ready) wbeats <= wbeats + 1;
      if (cmd_done) ndone <= ndone + 1;
      if (req_prev && !shmem_request) nfall <= nfall + 1;
      req_prev <= shmem_request;
      phase <= !phase;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic w, input logic [11:0] a, input logic [12:0] l);
      abase = nacc; rbase = nrd; dbase = ndone; fbase = nfall; wbase = wbeats;
      cmd_valid = 1'b1; cmd_wren = w; cmd_addr = a; cmd_len = l;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(output int c);
      c = 0;
      while (!cmd_done && c < 100) begin
         tick();
         c++;
      end
   endtask

   initial begin
      #3;
      chk("rst_req", shmem_request, 0);
      chk("rst_done", cmd_done, 0);
      chk("rst_rdv", rd_valid, 0);
      chk("rst_wrr", wr_ready, 0);
      chk("rst_cmdr", cmd_ready, 1);
      chk("rst_addr", shmem_addr, 0);
      tick();
      arst = 1'b0;
      tick();

      // write burst
      data_base = 32'd1; wv_en = 1'b1;
      cmd(1'b1, 12'h100, 13'd4);
      wait_done(cyc);
      chk("wb_done", cmd_done, 1);
      chk("wb_lat", cyc, 5);
      tick();
      chk("wb_pulse", cmd_done, 0);
      chk("wb_ndone", ndone - dbase, 1);
      chk("wb_nacc", nacc - abase, 4);
      for (int i = 0; i < 4; i++) begin
         chk("wb_addr", alog[abase + i], 32'h100 + i);
         chk("wb_mem", mem[12'h100 + i], 1 + i);
      end
      chk("wb_falls", nfall - fbase, 1);
      chk("wb_cmdr", cmd_ready, 1);

      // read burst
      rd_ready = 1'b1;
      cmd(1'b0, 12'h100, 13'd4);
      wait_done(cyc);
      chk("rb_done", cmd_done, 1);
      chk("rb_lat", cyc, 4);
      repeat (3) tick();
      chk("rb_nrd", nrd - rbase, 4);
      for (int i = 0; i < 4; i++) chk("rb_data", rlog[rbase + i], 1 + i);
      chk("rb_rdv", rd_valid, 0);

      // read backpressure
      rd_ready = 1'b0;
      cmd(1'b0, 12'h100, 13'd4);
      repeat (8) tick();
      chk("bp_nacc", nacc - abase, 2);
      chk("bp_req", shmem_request, 0);
      chk("bp_rdv", rd_valid, 1);
      chk("bp_head", rd_data, 1);
      chk("bp_cmdr", cmd_ready, 0);
      rd_ready = 1'b1;
      wait_done(cyc);
      chk("bp_done", cmd_done, 1);
      repeat (3) tick();
      chk("bp_nacc2", nacc - abase, 4);
      chk("bp_nrd", nrd - rbase, 4);
      for (int i = 0; i < 4; i++) chk("bp_data", rlog[rbase + i], 1 + i);
      chk("bp_rdv", rd_valid, 0);

      // address wrap
      data_base = 32'h10;
      cmd(1'b1, 12'hFFE, 13'd4);
      wait_done(cyc);
      chk("wr_lat", cyc, 5);
      tick();
      chk("wr_a0", alog[abase], 32'hFFE);
      chk("wr_a1", alog[abase + 1], 32'hFFF);
      chk("wr_a2", alog[abase + 2], 32'h000);
      chk("wr_a3", alog[abase + 3], 32'h001);
      chk("wr_m0", mem[12'hFFF], 32'h11);
      chk("wr_m1", mem[12'h000], 32'h12);

      // zero length
      cmd(1'b1, 12'h055, 13'd0);
      chk("z_done", cmd_done, 1);
      chk("z_req", shmem_request, 0);
      chk("z_cmdr", cmd_ready, 1);
      tick();
      chk("z_pulse", cmd_done, 0);
      repeat (3) tick();
      chk("z_nacc", nacc - abase, 0);
      chk("z_ndone", ndone - dbase, 1);

      // write with gaps
      data_base = 32'h20; gap = 1'b1;
      cmd(1'b1, 12'h200, 13'd3);
      wait_done(cyc);
      chk("g_done", cmd_done, 1);
      tick();
      chk("g_falls", nfall - fbase, 3);
      for (int i = 0; i < 3; i++) begin
         chk("g_addr", alog[abase + i], 32'h200 + i);
         chk("g_mem", mem[12'h200 + i], 32'h20 + i);
      end
      gap = 1'b0;

      // reset mid-write
      data_base = 32'h40;
      cmd(1'b1, 12'h300, 13'd8);
      repeat (3) tick();
      chk("r_reqhi", shmem_request, 1);
      chk("r_nacc", nacc - abase, 2);
      arst = 1'b1;
      #1;
      chk("r_reqlo", shmem_request, 0);
      chk("r_cmdr", cmd_ready, 1);
      chk("r_done", cmd_done, 0);
      tick();
      arst = 1'b0;
      repeat (3) tick();
      chk("r_ndone", ndone - dbase, 0);
      chk("r_nacc2", nacc - abase, 2);
      data_base = 32'h50;
      cmd(1'b1, 12'h310, 13'd2);
      wait_done(cyc);
      chk("r2_done", cmd_done, 1);
      tick();
      chk("r2_m0", mem[12'h310], 32'h50);
      chk("r2_m1", mem[12'h311], 32'h51);
      chk("r2_cmdr", cmd_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
